// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port 16-bit video RAM between pixel fetches
// and buffered CPU writes. Video reads always win a RAM cycle. CPU writes to
// 0x9000-0xBFFF are queued in a small FIFO and retired in otherwise idle cycles.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no RAM access this cycle; ram_addr/ram_wdata hold
// VRD   | video read cycle, ram_addr = sampled vid_addr
// WR    | FIFO head written to RAM (ram_we=1); head popped entering WR
module vram_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 14
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [15:0]   vid_data,
   output logic          vid_valid,
   input  logic [15:0]   cpu_addr,
   input  logic [7:0]    cpu_din,
   input  logic [7:0]    cpu_color,
   input  logic          cpu_we,
   output logic          wr_full,
   output logic          wr_ovf,
   output logic [AW-1:0] ram_addr,
   output logic [15:0]   ram_wdata,
   output logic          ram_we,
   input  logic [15:0]   ram_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_VRD, ST_WR} state_t;

   state_t state, state_nxt;

   logic [AW+15:0] fifo_mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [PW:0]    count, count_nxt;
   logic           fifo_empty;
   logic           win_hit, push, pop;
   logic [13:0]    win_addr;
   logic [AW+15:0] head;
   logic           rd_pend;

   // 0x9000 maps to RAM 0x0000; subtraction wraps modulo 2^14
   assign win_hit  = cpu_we & cpu_addr[15] & ~cpu_addr[14] & (cpu_addr[13] | cpu_addr[12]);
   assign win_addr = cpu_addr[13:0] - 14'h1000;

   assign fifo_empty = (count == '0);
   assign head       = fifo_mem[rd_ptr];
   assign pop        = (state_nxt == ST_WR);
   // a full FIFO still accepts a write when the head leaves in the same cycle
   assign push       = win_hit & ((count != DEPTH_C) | pop);

   // next RAM cycle: video first, then pending writes
   always_comb begin
      state_nxt = ST_IDLE;
      if (vid_req)
         state_nxt = ST_VRD;
      else if (!fifo_empty)
         state_nxt = ST_WR;
   end

   // FIFO occupancy after this cycle's push/pop
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // RAM-cycle state register
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // FIFO storage; contents are don't-care until pushed
   always_ff @(posedge clk_sys) begin
      if (push)
         fifo_mem[wr_ptr] <= {AW'(win_addr), cpu_color, cpu_din};
   end

   // FIFO pointers, count and status flags
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         wr_full <= 1'b0;
         wr_ovf  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count   <= count_nxt;
         wr_full <= (count_nxt == DEPTH_C);
         if (win_hit & ~push)
            wr_ovf <= 1'b1;
      end
   end

   // registered RAM controls for the upcoming cycle
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
      end else begin
         case (state_nxt)
            ST_VRD: begin
               ram_addr <= vid_addr;
               ram_we   <= 1'b0;
            end
            ST_WR: begin
               ram_addr  <= head[AW+15:16];
               ram_wdata <= head[15:0];
               ram_we    <= 1'b1;
            end
            default: ram_we <= 1'b0;
         endcase
      end
   end

   // read data arrives the cycle after VRD; capture it one cycle later
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rd_pend   <= 1'b0;
         vid_valid <= 1'b0;
         vid_data  <= '0;
      end else begin
         rd_pend   <= (state == ST_VRD);
         vid_valid <= rd_pend;
         if (rd_pend)
            vid_data <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: per-cycle vector table plus hand sequences for
// reset during a write burst and push-while-full with a simultaneous pop.
module tb_vram_arbiter;

   localparam int AW = 14;
   localparam int NV = 37;

   logic          clk_sys = 1'b0;
   logic          reset   = 1'b1;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic [15:0]   vid_data;
   logic          vid_valid;
   logic [15:0]   cpu_addr = '0;
   logic [7:0]    cpu_din = '0;
   logic [7:0]    cpu_color = '0;
   logic          cpu_we = 1'b0;
   logic          wr_full, wr_ovf;
   logic [AW-1:0] ram_addr;
   logic [15:0]   ram_wdata;
   logic          ram_we;
   logic [15:0]   ram_rdata = '0;

   logic [15:0]   mem [2**AW];
   logic          mem_init = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   vram_arbiter #(.DEPTH(4), .AW(AW)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_color(cpu_color), .cpu_we(cpu_we),
      .wr_full(wr_full), .wr_ovf(wr_ovf),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
   );

   always #5 clk_sys = ~clk_sys;

   // synchronous single-port RAM; unwritten words read as 0x8000 | address
   always @(posedge clk_sys) begin
      if (mem_init) begin
         for (int i = 0; i < 2**AW; i++)
            mem[i] <= 16'h8000 | 16'(i);
      end else begin
         if (ram_we)
            mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   typedef struct {
      logic          vreq;
      logic [AW-1:0] vaddr;
      logic          we;
      logic [15:0]   caddr;
      logic [7:0]    din;
      logic [7:0]    col;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [15:0]   e_wdata;
      logic          e_vv;
      logic [15:0]   e_vd;
      logic          e_full;
      logic          e_ovf;
   } vec_t;

   vec_t vecs [NV];

   function automatic vec_t mk(logic vr, logic [AW-1:0] va, logic w, logic [15:0] ca,
                               logic [7:0] d, logic [7:0] c, logic ew, logic [AW-1:0] ea,
                               logic [15:0] ed, logic evv, logic [15:0] evd, logic ef, logic eo);
      vec_t v;
      v.vreq = vr; v.vaddr = va; v.we = w; v.caddr = ca; v.din = d; v.col = c;
      v.e_we = ew; v.e_addr = ea; v.e_wdata = ed; v.e_vv = evv; v.e_vd = evd;
      v.e_full = ef; v.e_ovf = eo;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic vr, input logic [AW-1:0] va, input logic w,
                        input logic [15:0] ca, input logic [7:0] d, input logic [7:0] c);
      vid_req   = vr;
      vid_addr  = va;
      cpu_we    = w;
      cpu_addr  = ca;
      cpu_din   = d;
      cpu_color = c;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   initial begin
      bit seen, any_we;
      int k;

      //                 vreq vaddr    we caddr     din    col   | we addr      wdata     vv vdata     full ovf
      vecs[0]  = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0000, 16'h0000, 0, 16'h0000, 0, 0);
      vecs[1]  = mk(0, 14'h0000, 1, 16'h9005, 8'hA5, 8'h3C, 0, 14'h0000, 16'h0000, 0, 16'h0000, 0, 0);
      vecs[2]  = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0000, 16'h0000, 0, 16'h0000, 0, 0);
      vecs[3]  = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 1, 14'h0005, 16'h3CA5, 0, 16'h0000, 0, 0);
      vecs[4]  = mk(1, 14'h0005, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0005, 16'h3CA5, 0, 16'h0000, 0, 0);
      vecs[5]  = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0005, 16'h3CA5, 0, 16'h0000, 0, 0);
      vecs[6]  = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0005, 16'h3CA5, 0, 16'h0000, 0, 0);
      vecs[7]  = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0005, 16'h3CA5, 1, 16'h3CA5, 0, 0);
      vecs[8]  = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0005, 16'h3CA5, 0, 16'h3CA5, 0, 0);
      // window boundaries
      vecs[9]  = mk(0, 14'h0000, 1, 16'h8FFF, 8'h11, 8'h01, 0, 14'h0005, 16'h3CA5, 0, 16'h3CA5, 0, 0);
      vecs[10] = mk(0, 14'h0000, 1, 16'h9000, 8'h22, 8'h02, 0, 14'h0005, 16'h3CA5, 0, 16'h3CA5, 0, 0);
      vecs[11] = mk(0, 14'h0000, 1, 16'hBFFF, 8'h33, 8'h03, 0, 14'h0005, 16'h3CA5, 0, 16'h3CA5, 0, 0);
      vecs[12] = mk(0, 14'h0000, 1, 16'hC000, 8'h44, 8'h04, 1, 14'h0000, 16'h0222, 0, 16'h3CA5, 0, 0);
      vecs[13] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 1, 14'h2FFF, 16'h0333, 0, 16'h3CA5, 0, 0);
      vecs[14] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h2FFF, 16'h0333, 0, 16'h3CA5, 0, 0);
      // priority: video reads ahead of three queued writes
      vecs[15] = mk(0, 14'h0000, 1, 16'h9100, 8'h01, 8'h10, 0, 14'h2FFF, 16'h0333, 0, 16'h3CA5, 0, 0);
      vecs[16] = mk(1, 14'h0100, 1, 16'hA200, 8'h02, 8'h20, 0, 14'h2FFF, 16'h0333, 0, 16'h3CA5, 0, 0);
      vecs[17] = mk(1, 14'h0000, 1, 16'hB300, 8'h03, 8'h30, 0, 14'h0100, 16'h0333, 0, 16'h3CA5, 0, 0);
      vecs[18] = mk(1, 14'h2FFF, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0000, 16'h0333, 0, 16'h3CA5, 0, 0);
      vecs[19] = mk(1, 14'h0005, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h2FFF, 16'h0333, 1, 16'h8100, 0, 0);
      vecs[20] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0005, 16'h0333, 1, 16'h0222, 0, 0);
      vecs[21] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 1, 14'h0100, 16'h1001, 1, 16'h0333, 0, 0);
      vecs[22] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 1, 14'h1200, 16'h2002, 1, 16'h3CA5, 0, 0);
      vecs[23] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 1, 14'h2300, 16'h3003, 0, 16'h3CA5, 0, 0);
      vecs[24] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h2300, 16'h3003, 0, 16'h3CA5, 0, 0);
      // overflow under continuous video requests
      vecs[25] = mk(1, 14'h0000, 1, 16'h9010, 8'h41, 8'h51, 0, 14'h2300, 16'h3003, 0, 16'h3CA5, 0, 0);
      vecs[26] = mk(1, 14'h2FFF, 1, 16'h9011, 8'h42, 8'h52, 0, 14'h0000, 16'h3003, 0, 16'h3CA5, 0, 0);
      vecs[27] = mk(1, 14'h0100, 1, 16'h9012, 8'h43, 8'h53, 0, 14'h2FFF, 16'h3003, 0, 16'h3CA5, 0, 0);
      vecs[28] = mk(1, 14'h0005, 1, 16'h9013, 8'h44, 8'h54, 0, 14'h0100, 16'h3003, 1, 16'h0222, 0, 0);
      vecs[29] = mk(1, 14'h0000, 1, 16'h9014, 8'h45, 8'h55, 0, 14'h0005, 16'h3003, 1, 16'h0333, 1, 0);
      vecs[30] = mk(1, 14'h2FFF, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0000, 16'h3003, 1, 16'h1001, 1, 1);
      vecs[31] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h2FFF, 16'h3003, 1, 16'h3CA5, 1, 1);
      vecs[32] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 1, 14'h0010, 16'h5141, 1, 16'h0222, 0, 1);
      vecs[33] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 1, 14'h0011, 16'h5242, 1, 16'h0333, 0, 1);
      vecs[34] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 1, 14'h0012, 16'h5343, 0, 16'h0333, 0, 1);
      vecs[35] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 1, 14'h0013, 16'h5444, 0, 16'h0333, 0, 1);
      vecs[36] = mk(0, 14'h0000, 0, 16'h0000, 8'h00, 8'h00, 0, 14'h0013, 16'h5444, 0, 16'h0333, 0, 1);

      reset = 1'b1;
      @(posedge clk_sys);
      #1 mem_init = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(posedge clk_sys);
         #1 drive(vecs[i].vreq, vecs[i].vaddr, vecs[i].we, vecs[i].caddr, vecs[i].din, vecs[i].col);
         @(negedge clk_sys);
         chk($sformatf("v%0d_ram_we", i),    16'(ram_we),    16'(vecs[i].e_we));
         chk($sformatf("v%0d_ram_addr", i),  16'(ram_addr),  16'(vecs[i].e_addr));
         chk($sformatf("v%0d_ram_wdata", i), ram_wdata,      vecs[i].e_wdata);
         chk($sformatf("v%0d_vid_valid", i), 16'(vid_valid), 16'(vecs[i].e_vv));
         chk($sformatf("v%0d_vid_data", i),  vid_data,       vecs[i].e_vd);
         chk($sformatf("v%0d_wr_full", i),   16'(wr_full),   16'(vecs[i].e_full));
         chk($sformatf("v%0d_wr_ovf", i),    16'(wr_ovf),    16'(vecs[i].e_ovf));
      end

      // reset asserted during a WR cycle with two entries still queued
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_sys);
         #1 drive(1'b1, 14'h0000, 1'b1, 16'(16'h9030 + i), 8'h01, 8'h02);
      end
      @(posedge clk_sys);
      #1 drive(1'b0, 14'h0000, 1'b0, 16'h0000, 8'h00, 8'h00);
      seen = 1'b0;
      k = 0;
      while (!seen && k < 10) begin
         @(negedge clk_sys);
         if (ram_we) seen = 1'b1;
         k++;
      end
      chk("rst_wr_reached", 16'(seen), 16'd1);
      reset = 1'b1;
      #1;
      chk("rst_we_async", 16'(ram_we), 16'd0);
      chk("rst_ovf", 16'(wr_ovf), 16'd0);
      chk("rst_full", 16'(wr_full), 16'd0);
      chk("rst_vvalid", 16'(vid_valid), 16'd0);
      chk("rst_vdata", vid_data, 16'h0000);
      chk("rst_addr", 16'(ram_addr), 16'h0000);
      @(negedge clk_sys);
      reset = 1'b0;
      any_we = 1'b0;
      repeat (8) begin
         @(negedge clk_sys);
         any_we |= ram_we;
      end
      chk("rst_no_we_after", 16'(any_we), 16'd0);

      // full FIFO, no video request, write arrives in the pop cycle
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_sys);
         #1 drive(1'b1, 14'h0000, 1'b1, 16'(16'h9040 + i), 8'(8'h80 + i), 8'(8'h90 + i));
      end
      @(posedge clk_sys);
      #1 drive(1'b0, 14'h0000, 1'b1, 16'h9044, 8'h84, 8'h94);
      @(negedge clk_sys);
      chk("pf_full_before", 16'(wr_full), 16'd1);
      @(posedge clk_sys);
      #1 drive(1'b0, 14'h0000, 1'b0, 16'h0000, 8'h00, 8'h00);
      for (int j = 0; j < 5; j++) begin
         @(negedge clk_sys);
         if (j == 0) begin
            chk("pf_full_kept", 16'(wr_full), 16'd1);
            chk("pf_ovf", 16'(wr_ovf), 16'd0);
         end
         chk($sformatf("pf%0d_we", j),    16'(ram_we),   16'd1);
         chk($sformatf("pf%0d_addr", j),  16'(ram_addr), 16'(16'h0040 + j));
         chk($sformatf("pf%0d_wdata", j), ram_wdata,     {8'(8'h90 + j), 8'(8'h80 + j)});
      end
      @(negedge clk_sys);
      chk("pf_done_we", 16'(ram_we), 16'd0);
      chk("pf_done_ovf", 16'(wr_ovf), 16'd0);
      chk("pf_done_full", 16'(wr_full), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Time-shares one single-port 16-bit video RAM between the pixel fetch path and CPU bus writes. Video reads always win a RAM cycle. CPU writes in the window 0x9000–0xBFFF are buffered in a small FIFO and retired in idle RAM cycles. The block sits between the CPU bus decode, the video timing/shift logic and the RAM macro, and replaces the dual-port VRAM.

## Interface
Parameters:
- `DEPTH`, default 4: write FIFO entries; must be a power of 2 and at least 2.
- `AW`, default 14: RAM address width.

Ports (clock and reset first):
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `vid_req` in 1: one-cycle strobe requesting a fetch.
- `vid_addr` in AW: fetch address, sampled with `vid_req`.
- `vid_data` out 16: fetched word as {color, bitmap}.
- `vid_valid` out 1: one-cycle strobe; `vid_data` is valid in that cycle.
- `cpu_addr` in 16: CPU address.
- `cpu_din` in 8: bitmap byte.
- `cpu_color` in 8: colour attribute latched with the byte.
- `cpu_we` in 1: one-cycle write strobe.
- `wr_full` out 1: FIFO holds DEPTH entries.
- `wr_ovf` out 1: sticky flag; a write was dropped.
- `ram_addr` out AW: RAM address, registered.
- `ram_wdata` out 16: RAM write data, registered.
- `ram_we` out 1: RAM write enable, registered.
- `ram_rdata` in 16: RAM read data, valid one cycle after the read cycle.

## Operation
- Window decode: a write hits when `cpu_we & cpu_addr[15] & ~cpu_addr[14] & (cpu_addr[13] | cpu_addr[12])`.
  - RAM address is `cpu_addr[13:0] - 14'h1000`, modulo 2^14, so 0x9000 maps to 0x0000 and 0xBFFF maps to 0x2FFF.
  - Strobes outside the window are ignored and never touch `wr_ovf`.
- FIFO entry is {ram address, cpu_color, cpu_din}, with colour in bits [15:8].
- Push rule: a hit is accepted when count < DEPTH, or when a pop happens in the same cycle.
  - Otherwise the write is dropped and `wr_ovf` is set to 1 until reset.
- `wr_full` = (count == DEPTH), registered.
- RAM-cycle state machine, evaluated every clock: IDLE, VRD, WR.
  - Any state goes to VRD if `vid_req`=1.
  - Otherwise it goes to WR if the FIFO is non-empty at the start of the cycle.
  - Otherwise it goes to IDLE.
- Per state:
  - VRD: `ram_addr` = sampled `vid_addr`, `ram_we`=0.
  - WR: `ram_addr`/`ram_wdata` = FIFO head, `ram_we`=1; the head pops on the transition into WR.
  - IDLE: `ram_we`=0; `ram_addr` and `ram_wdata` hold.
- Read return: one cycle after a VRD cycle, `vid_data` <= `ram_rdata` and `vid_valid` <= 1. `vid_valid` is 0 otherwise.
- No bypass: an entry pushed in cycle N reaches the RAM no earlier than cycle N+2.
- No coherence: a video read of an address with a pending FIFO write returns the old RAM contents.
- Starvation: continuous `vid_req` blocks writes. The video path issues at most one request per 8 pixel clocks, which bounds write latency.

## Timing
- `vid_req` at cycle N: VRD at N+1, `ram_rdata` at N+2, `vid_valid`=1 with data at N+3. Fixed latency is 3.
- `vid_req` on consecutive cycles gives consecutive VRD cycles and consecutive `vid_valid` pulses, in order.
- `cpu_we` hit at N with FIFO empty and no `vid_req`: entry is present at N+1, WR cycle (`ram_we`=1) at N+2.
- `vid_req` and a pending write in the same cycle: VRD first, WR in the next cycle without a request.
- Push and pop in the same cycle: count is unchanged; pointers wrap modulo DEPTH.
- Reset values:
  - state IDLE, FIFO empty, pointers 0.
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `vid_valid`=0, `vid_data`=0.
  - `wr_full`=0, `wr_ovf`=0.
- Reset mid-operation: a reset asserted during WR drops `ram_we` immediately (asynchronously). Pending FIFO entries and any in-flight read result are discarded.

## Test plan
- Single write then read:
  - Stimulus: `cpu_we` at addr 0x9005, din 0xA5, color 0x3C, then `vid_req` addr 0x0005 after the write retires.
  - Response: `ram_we` pulse with addr 0x0005, wdata 0x3CA5; `vid_data`=0x3CA5 three cycles after `vid_req`.
- Window boundaries:
  - Stimulus: writes to 0x8FFF, 0x9000, 0xBFFF, 0xC000.
  - Response: only RAM addrs 0x0000 and 0x2FFF are written; `wr_ovf` stays 0.
- Priority:
  - Stimulus: 3 writes queued, then `vid_req` held high for 4 cycles.
  - Response: 4 VRD cycles first, then the 3 WR cycles in FIFO order; 4 `vid_valid` pulses at request+3.
- Overflow:
  - Stimulus: `vid_req` held high continuously while DEPTH+1 writes are issued.
  - Response: `wr_full`=1 after the 4th write; the 5th is dropped and `wr_ovf`=1; the first 4 retire once `vid_req` drops.
- Push while full with pop:
  - Stimulus: FIFO full, `vid_req`=0, a write strobe in the pop cycle.
  - Response: write accepted, count stays 4, `wr_ovf` stays 0.
- Reset mid-operation:
  - Stimulus: assert `reset` during WR with 2 entries pending.
  - Response: `ram_we` drops to 0 asynchronously; after release the FIFO is empty and no further `ram_we` occurs.
